sys_cmd_ctrl: RTL and testbench
===============================

Name: sys_cmd_ctrl

Overview:
- Command sequencer between the UART receive/transmit path and the register file and ALU.
- Decodes the byte stream delivered by UART RX into four commands: RF write (0xAA), RF read (0xBB), ALU with operands (0xCC), ALU without operands (0xDD).
- Drives register-file and ALU control strobes for each command.
- Returns read data and ALU results to UART TX through a valid/busy handshake.
- Sits in the REF_CLK domain; RX/TX data arrive already synchronized.

Parameters:
DATA_WIDTH, 8, byte width of RX/TX/RF data
ADDR_WIDTH, 4, register-file address width
ALU_FUN_WIDTH, 4, ALU function select width

Ports:
REF_CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
RF_ADDR  out  ADDR_WIDTH  register-file address
RF_WR_EN  out  1  RF write strobe
RF_RD_EN  out  1  RF read strobe
RF_WR_DATA  out  DATA_WIDTH  RF write data
RF_RD_DATA  in  DATA_WIDTH  RF read data
RF_RD_VLD  in  1  RF read data valid (pulse)
ALU_EN  out  1  ALU enable
ALU_FUN  out  ALU_FUN_WIDTH  ALU function select
CLK_GATE_EN  out  1  ALU clock-gate enable
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid (pulse)
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  transmit request
TX_BUSY  in  1  transmitter busy

Behaviour:
- Reset: all outputs 0; state IDLE; capture registers cleared. Reset mid-command aborts it; no pending strobes after release.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI, TX_DONE.
- All byte-consuming states advance only on an RX_D_VLD pulse. Otherwise they hold.
- IDLE:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xCC -> OPA.
  - 0xDD -> FUN.
  - Any other byte is ignored; stay IDLE.
- RF write (0xAA):
  - WR_ADDR latches RX_P_DATA[ADDR_WIDTH-1:0]; upper bits are discarded.
  - WR_DATA issues a one-cycle RF_WR_EN with RF_ADDR and RF_WR_DATA = byte, in the cycle after the data byte's RX_D_VLD.
  - Then -> IDLE.
- RF read (0xBB):
  - RD_ADDR latches the address, then pulses RF_RD_EN for one cycle with RF_ADDR.
  - RD_WAIT waits for RF_RD_VLD and captures RF_RD_DATA.
  - Then -> TX_LO, single byte.
- ALU with operands (0xCC):
  - OPA writes the byte to RF address 0 (one-cycle RF_WR_EN).
  - OPB writes the byte to RF address 1 (one-cycle RF_WR_EN).
  - Then -> FUN.
- FUN:
  - Latches ALU_FUN = RX_P_DATA[ALU_FUN_WIDTH-1:0].
  - Asserts CLK_GATE_EN and ALU_EN from the cycle after the byte.
  - Then -> ALU_WAIT.
- ALU_WAIT:
  - ALU_EN and CLK_GATE_EN stay high until ALU_OUT_VLD.
  - On ALU_OUT_VLD, captures 16-bit ALU_OUT and drops ALU_EN/CLK_GATE_EN next cycle.
  - Then -> TX_LO, two bytes.
- TX handshake:
  - In TX_LO, when TX_BUSY=0, drive TX_P_DATA = low byte and raise TX_D_VLD.
  - Hold TX_D_VLD and TX_P_DATA stable until TX_BUSY=1 is sampled, then drop TX_D_VLD.
  - For a two-byte result, TX_HI waits for TX_BUSY=0, then repeats the handshake with the high byte.
  - TX_DONE waits for TX_BUSY=0, then -> IDLE.
- RX bytes arriving outside a byte-consuming state (RD_WAIT, ALU_WAIT, TX_*) are dropped.
- Simultaneous RX_D_VLD and state exit: the byte is consumed only by the current state.
- Any bus address or data value is permitted; the block performs no range checks.

Test Plan:
- RX AA,05,77 -> one RF_WR_EN pulse, RF_ADDR=5, RF_WR_DATA=0x77; no TX activity; back to IDLE.
- RX BB,02; RF returns 0x81 two cycles after RF_RD_EN -> RF_RD_EN pulse at ADDR=2; TX_P_DATA=0x81 with TX_D_VLD held until TX_BUSY; one byte only.
- RX CC,05,03,01; ALU_OUT=0x0002 -> RF writes addr0=0x05, addr1=0x03; ALU_FUN=1; ALU_EN/CLK_GATE_EN high until ALU_OUT_VLD; TX bytes 0x02 then 0x00.
- RX DD,00; ALU_OUT=0x01F4 -> no RF writes; ALU_FUN=0; TX 0xF4 then 0x01; second byte not sent until TX_BUSY falls.
- RX 55 then AA,0F,10 -> 0x55 ignored; write addr 0xF data 0x10.
- RX AA,05 then RST pulse, then BB,05 -> no RF_WR_EN ever issued; read proceeds normally after reset.

Source files
------------

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes UART RX bytes into register-file and ALU commands
// and returns read data / ALU results to UART TX over a valid/busy handshake.
module sys_cmd_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_FUN_WIDTH = 4
) (
   input  logic                      REF_CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
   input  logic                      RX_D_VLD,
   output logic [ADDR_WIDTH-1:0]     RF_ADDR,
   output logic                      RF_WR_EN,
   output logic                      RF_RD_EN,
   output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
   input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
   input  logic                      RF_RD_VLD,
   output logic                      ALU_EN,
   output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
   output logic                      CLK_GATE_EN,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      ALU_OUT_VLD,
   output logic [DATA_WIDTH-1:0]     TX_P_DATA,
   output logic                      TX_D_VLD,
   input  logic                      TX_BUSY,
   output logic [3:0]                dbg_state
);

   // TX handshake: TX_D_VLD is raised only while TX_BUSY is low, then held with
   // TX_P_DATA stable until TX_BUSY is sampled high, at which point it drops.
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ADDR  = 4'd1,
      WR_DATA  = 4'd2,
      RD_ADDR  = 4'd3,
      RD_WAIT  = 4'd4,
      OPA      = 4'd5,
      OPB      = 4'd6,
      FUN      = 4'd7,
      ALU_WAIT = 4'd8,
      TX_LO    = 4'd9,
      TX_HI    = 4'd10,
      TX_DONE  = 4'd11
   } state_t;

   localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [2*DATA_WIDTH-1:0] result;
   logic                    two_byte;

   assign dbg_state = state;

   always_ff @(posedge REF_CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         wr_addr     <= '0;
         result      <= '0;
         two_byte    <= 1'b0;
         RF_ADDR     <= '0;
         RF_WR_EN    <= 1'b0;
         RF_RD_EN    <= 1'b0;
         RF_WR_DATA  <= '0;
         ALU_EN      <= 1'b0;
         ALU_FUN     <= '0;
         CLK_GATE_EN <= 1'b0;
         TX_P_DATA   <= '0;
         TX_D_VLD    <= 1'b0;
      end else begin
         RF_WR_EN <= 1'b0;
         RF_RD_EN <= 1'b0;
         case (state)
            IDLE: begin
               if (RX_D_VLD) begin
                  case (RX_P_DATA)
                     CMD_RF_WR:   state <= WR_ADDR;
                     CMD_RF_RD:   state <= RD_ADDR;
                     CMD_ALU_OP:  state <= OPA;
                     CMD_ALU_NOP: state <= FUN;
                     default:     state <= IDLE;
                  endcase
               end
            end
            WR_ADDR: if (RX_D_VLD) begin
               wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
               state   <= WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
               RF_WR_EN   <= 1'b1;
               RF_ADDR    <= wr_addr;
               RF_WR_DATA <= RX_P_DATA;
               state      <= IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
               RF_RD_EN <= 1'b1;
               RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
               state    <= RD_WAIT;
            end
            RD_WAIT: if (RF_RD_VLD) begin
               result   <= {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
               two_byte <= 1'b0;
               state    <= TX_LO;
            end
            // Operands land in RF addresses 0 and 1, where the ALU reads them.
            OPA: if (RX_D_VLD) begin
               RF_WR_EN   <= 1'b1;
               RF_ADDR    <= '0;
               RF_WR_DATA <= RX_P_DATA;
               state      <= OPB;
            end
            OPB: if (RX_D_VLD) begin
               RF_WR_EN   <= 1'b1;
               RF_ADDR    <= ADDR_WIDTH'(1);
               RF_WR_DATA <= RX_P_DATA;
               state      <= FUN;
            end
            FUN: if (RX_D_VLD) begin
               ALU_FUN     <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
               ALU_EN      <= 1'b1;
               CLK_GATE_EN <= 1'b1;
               state       <= ALU_WAIT;
            end
            ALU_WAIT: if (ALU_OUT_VLD) begin
               result      <= ALU_OUT;
               ALU_EN      <= 1'b0;
               CLK_GATE_EN <= 1'b0;
               two_byte    <= 1'b1;
               state       <= TX_LO;
            end
            TX_LO, TX_HI: begin
               if (!TX_D_VLD) begin
                  if (!TX_BUSY) begin
                     TX_P_DATA <= (state == TX_HI) ? result[2*DATA_WIDTH-1:DATA_WIDTH]
                                                   : result[DATA_WIDTH-1:0];
                     TX_D_VLD  <= 1'b1;
                  end
               end else if (TX_BUSY) begin
                  TX_D_VLD <= 1'b0;
                  state    <= (state == TX_LO && two_byte) ? TX_HI : TX_DONE;
               end
            end
            TX_DONE: if (!TX_BUSY) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl with a small UART TX responder and strobe monitor.
module tb_sys_cmd_ctrl;

   logic        REF_CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [3:0]  RF_ADDR;
   logic        RF_WR_EN;
   logic        RF_RD_EN;
   logic [7:0]  RF_WR_DATA;
   logic [7:0]  RF_RD_DATA = '0;
   logic        RF_RD_VLD = 1'b0;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLK_GATE_EN;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VLD = 1'b0;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_BUSY = 1'b0;
   logic [3:0]  dbg_state;

   sys_cmd_ctrl dut (
      .REF_CLK(REF_CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
      .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
      .dbg_state(dbg_state)
   );

   localparam logic [3:0] S_IDLE = 4'd0;

   always #5 REF_CLK = ~REF_CLK;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int tx_viol = 0;
   logic [7:0] tx_q[$];
   logic       prev_vld = 1'b0;
   logic [7:0] prev_data = '0;

   // Strobe counters and TX handshake rule monitor.
   always @(negedge REF_CLK) begin
      if (!RST) begin
         if (RF_WR_EN) wr_cnt <= wr_cnt + 1;
         if (RF_RD_EN) rd_cnt <= rd_cnt + 1;
         if (TX_D_VLD && !prev_vld && TX_BUSY) tx_viol <= tx_viol + 1;
         if (TX_D_VLD && prev_vld && TX_P_DATA !== prev_data) tx_viol <= tx_viol + 1;
         if (!TX_D_VLD && prev_vld && !TX_BUSY) tx_viol <= tx_viol + 1;
      end
      prev_vld  <= TX_D_VLD;
      prev_data <= TX_P_DATA;
   end

   // Transmitter model: accept a byte, stay idle two cycles, then busy for four.
   always begin
      @(negedge REF_CLK);
      if (!RST && TX_D_VLD && !TX_BUSY) begin
         tx_q.push_back(TX_P_DATA);
         repeat (2) @(negedge REF_CLK);
         TX_BUSY = 1'b1;
         repeat (4) @(negedge REF_CLK);
         TX_BUSY = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge REF_CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      tick();
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      logic ok;
      int   n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 300) begin
         tick();
         n++;
         if (dbg_state == S_IDLE) ok = 1'b1;
      end
      chk(tag, ok, 1);
   endtask

   task automatic rf_return(input logic [7:0] d);
      RF_RD_DATA = d;
      RF_RD_VLD  = 1'b1;
      tick();
      RF_RD_VLD  = 1'b0;
   endtask

   task automatic alu_return(input logic [15:0] r);
      ALU_OUT     = r;
      ALU_OUT_VLD = 1'b1;
      tick();
      ALU_OUT_VLD = 1'b0;
   endtask

   int wr_base, rd_base, tx_base, viol_base;

   task automatic mark();
      wr_base   = wr_cnt;
      rd_base   = rd_cnt;
      tx_base   = tx_q.size();
      viol_base = tx_viol;
   endtask

   initial begin
      // Reset
      RST = 1'b1;
      repeat (3) tick();
      chk("reset_outs", {RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN,
                         CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
      chk("reset_state", dbg_state, S_IDLE);
      RST = 1'b0;
      tick();

      // RF write AA,05,77
      mark();
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h77);
      chk("wr_en", RF_WR_EN, 1);
      chk("wr_addr", RF_ADDR, 4'h5);
      chk("wr_data", RF_WR_DATA, 8'h77);
      repeat (10) tick();
      chk("wr_pulses", wr_cnt - wr_base, 1);
      chk("wr_no_tx", tx_q.size() - tx_base, 0);
      chk("wr_idle", dbg_state, S_IDLE);

      // RF read BB,02 -> 0x81
      mark();
      send_byte(8'hBB); send_byte(8'h02);
      chk("rd_en", RF_RD_EN, 1);
      chk("rd_addr", RF_ADDR, 4'h2);
      tick();
      chk("rd_en_pulse", RF_RD_EN, 0);
      tick();
      rf_return(8'h81);
      wait_idle("rd_done");
      chk("rd_tx_count", tx_q.size() - tx_base, 1);
      chk("rd_tx_byte", tx_q[tx_base], 8'h81);
      chk("rd_tx_hs", tx_viol - viol_base, 0);
      chk("rd_pulses", rd_cnt - rd_base, 1);
      chk("rd_no_wr", wr_cnt - wr_base, 0);

      // ALU with operands CC,05,03,01 -> 0x0002
      mark();
      send_byte(8'hCC);
      send_byte(8'h05);
      chk("opa_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h0, 8'h05});
      send_byte(8'h03);
      chk("opb_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h1, 8'h03});
      send_byte(8'h01);
      chk("alu_start", {ALU_EN, CLK_GATE_EN, ALU_FUN}, {1'b1, 1'b1, 4'h1});
      repeat (3) tick();
      chk("alu_hold", {ALU_EN, CLK_GATE_EN}, 2'b11);
      alu_return(16'h0002);
      chk("alu_drop", {ALU_EN, CLK_GATE_EN}, 2'b00);
      wait_idle("alu_done");
      chk("alu_tx_count", tx_q.size() - tx_base, 2);
      chk("alu_tx_lo", tx_q[tx_base], 8'h02);
      chk("alu_tx_hi", tx_q[tx_base + 1], 8'h00);
      chk("alu_wr_pulses", wr_cnt - wr_base, 2);
      chk("alu_tx_hs", tx_viol - viol_base, 0);

      // ALU without operands DD,00 -> 0x01F4, stray 0xBB during ALU_WAIT dropped
      mark();
      send_byte(8'hDD); send_byte(8'h00);
      chk("nop_start", {ALU_EN, CLK_GATE_EN, ALU_FUN}, {1'b1, 1'b1, 4'h0});
      send_byte(8'hBB);
      chk("nop_hold", ALU_EN, 1);
      alu_return(16'h01F4);
      wait_idle("nop_done");
      chk("nop_tx_count", tx_q.size() - tx_base, 2);
      chk("nop_tx_lo", tx_q[tx_base], 8'hF4);
      chk("nop_tx_hi", tx_q[tx_base + 1], 8'h01);
      chk("nop_no_wr", wr_cnt - wr_base, 0);
      chk("nop_no_rd", rd_cnt - rd_base, 0);
      chk("nop_tx_hs", tx_viol - viol_base, 0);

      // Unknown byte ignored, then write to top address
      mark();
      send_byte(8'h55);
      repeat (2) tick();
      chk("junk_idle", dbg_state, S_IDLE);
      send_byte(8'hAA); send_byte(8'h0F); send_byte(8'h10);
      chk("top_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'hF, 8'h10});
      repeat (2) tick();
      chk("top_pulses", wr_cnt - wr_base, 1);

      // Upper address bits discarded
      mark();
      send_byte(8'hAA); send_byte(8'hF3); send_byte(8'hC4);
      chk("trunc_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h3, 8'hC4});

      // Reset mid-command aborts the write
      repeat (2) tick();
      mark();
      send_byte(8'hAA); send_byte(8'h05);
      RST = 1'b1;
      tick(); tick();
      chk("abort_state", dbg_state, S_IDLE);
      RST = 1'b0;
      tick();
      send_byte(8'hBB); send_byte(8'h05);
      chk("post_rst_rd", {RF_RD_EN, RF_ADDR}, {1'b1, 4'h5});
      tick(); tick();
      rf_return(8'h3C);
      wait_idle("post_rst_done");
      chk("post_rst_tx_count", tx_q.size() - tx_base, 1);
      chk("post_rst_tx", tx_q[tx_base], 8'h3C);
      chk("post_rst_no_wr", wr_cnt - wr_base, 0);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
